id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the ARMv8 five-stage core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID, and presents ex_Rn/ex_Rm/ex_Rd/ex_RegWrite to the EX stage and the operand-forwarding unit.
- Inserts a one-cycle bubble when the EX-stage instruction is a load whose destination is a source of the ID-stage instruction. This case cannot be covered by forwarding.
- Also supports an external freeze (hold) and a branch flush, and counts stall cycles for performance monitoring.

Parameters:
- DATA_W, 64, width of operand, immediate and PC fields
- ALUOP_W, 4, width of ALU operation code
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  input  1  core clock, rising-edge
- rst  input  1  asynchronous active-high reset
- id_valid  input  1  ID slot holds a real instruction
- id_Rn  input  5  first source register
- id_Rm  input  5  second source register
- id_uses_Rm  input  1  instruction actually reads Rm; when 0, Rm is ignored for the hazard check
- id_Rd  input  5  destination register
- id_RegWrite  input  1  writes the register file
- id_MemRead  input  1  load
- id_MemWrite  input  1  store
- id_ALUSrc  input  1  immediate selects operand B
- id_ALUop  input  ALUOP_W  ALU operation
- id_rdata1  input  DATA_W  register-file read of Rn
- id_rdata2  input  DATA_W  register-file read of Rm
- id_imm  input  DATA_W  sign-extended immediate
- id_pc  input  DATA_W  instruction PC
- hold  input  1  downstream freeze; the register keeps its contents
- flush  input  1  branch taken; kill the ID-stage instruction
- ex_valid, ex_Rn, ex_Rm, ex_Rd, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_ALUop, ex_rdata1, ex_rdata2, ex_imm, ex_pc  output  widths as the id_ counterparts  registered EX-stage copies
- stall_req  output  1  combinational; freezes PC and IF/ID this cycle
- stall_cnt  output  CNT_W  saturating count of cycles a bubble was inserted

Behaviour:
- Reset (asynchronous, immediate): all ex_ outputs 0 except ex_Rd = 5'd31. stall_cnt = 0.
- Hazard term, combinational:
  - haz = ex_valid & ex_MemRead & (ex_Rd != 31) & id_valid & ((ex_Rd == id_Rn) | (id_uses_Rm & (ex_Rd == id_Rm))).
  - stall_req = haz & ~flush.
  - X31 (XZR/SP) is never a hazard source.
- Register update at each posedge, highest priority first:
  1. flush: load a bubble.
  2. hold: retain all fields unchanged.
  3. haz: load a bubble.
  4. otherwise: load all id_ fields; ex_valid = id_valid.
- Bubble definition: ex_valid, ex_RegWrite, ex_MemRead and ex_MemWrite = 0; ex_Rd = 31; all other fields 0. A bubble therefore never matches in the forwarding unit.
- Latency: one cycle from ID capture to EX outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_MemRead = 0, so haz deasserts. The ID instruction, held by the upstream freeze, enters on the following edge.
- hold with haz:
  - The register holds; the bubble is deferred.
  - stall_req stays asserted while haz is true, so upstream also holds.
- flush with haz: flush wins. The bubble is loaded, stall_req = 0, and stall_cnt does not increment.
- stall_cnt:
  - Increments on each edge where a hazard bubble is actually loaded, i.e. ~flush & ~hold & haz.
  - Saturates at all-ones; it does not wrap.
- id_valid = 0 with no stall/flush/hold: fields load as given, ex_valid = 0, and ex_RegWrite is taken from id_RegWrite as-is. Upstream guarantees RegWrite = 0 when invalid.

Test Plan:
- Reset mid-stream: after loading {Rd=5, RegWrite=1}, assert rst asynchronously between edges. Outputs clear immediately: ex_Rd=31, ex_RegWrite=0, stall_cnt=0.
- Load-use on Rn:
  - Cycle 0: load EX = {MemRead=1, Rd=3}. Cycle 1: ID = {Rn=3}. stall_req=1 in cycle 1.
  - Next edge loads a bubble (ex_Rd=31, ex_valid=0) and stall_cnt becomes 1.
  - Following edge loads the Rn=3 instruction; stall_req=0.
- Rm hazard gating:
  - EX load Rd=7; ID Rm=7 with id_uses_Rm=0: stall_req=0, normal load.
  - Repeat with id_uses_Rm=1: stall_req=1.
- XZR exclusion: EX load Rd=31, ID Rn=31 -> stall_req=0, no bubble.
- flush priority: hazard present and flush=1 -> stall_req=0, bubble loaded, stall_cnt unchanged.
- hold with hazard:
  - hold=1 for 3 cycles: ex_ outputs unchanged, stall_req=1 throughout, stall_cnt unchanged.
  - Release hold: one bubble loaded and stall_cnt increments by 1.
  - Separately, preload stall_cnt near max (force) and trigger bubbles: the counter saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, freeze, flush and a
// saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [4:0]         id_Rn,
    input  logic [4:0]         id_Rm,
    input  logic               id_uses_Rm,
    input  logic [4:0]         id_Rd,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_ALUSrc,
    input  logic [ALUOP_W-1:0] id_ALUop,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic               hold,
    input  logic               flush,
    output logic               ex_valid,
    output logic [4:0]         ex_Rn,
    output logic [4:0]         ex_Rm,
    output logic [4:0]         ex_Rd,
    output logic               ex_RegWrite,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_ALUSrc,
    output logic [ALUOP_W-1:0] ex_ALUop,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc,
    output logic               stall_req,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic haz;
    logic load_bubble;
    logic load_id;
    logic count_en;

    // X31 is XZR/SP and never carries a loaded value, so it cannot create a hazard.
    assign haz = ex_valid & ex_MemRead & (ex_Rd != 5'd31) & id_valid &
                 ((ex_Rd == id_Rn) | (id_uses_Rm & (ex_Rd == id_Rm)));

    assign stall_req   = haz & ~flush;
    assign load_bubble = flush | (~hold & haz);
    assign load_id     = ~flush & ~hold & ~haz;
    assign count_en    = ~flush & ~hold & haz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_Rn       <= 5'd0;
            ex_Rm       <= 5'd0;
            ex_Rd       <= 5'd31;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_ALUop    <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
        end else if (load_bubble) begin
            // Rd = 31 keeps the bubble invisible to the forwarding unit.
            ex_valid    <= 1'b0;
            ex_Rn       <= 5'd0;
            ex_Rm       <= 5'd0;
            ex_Rd       <= 5'd31;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_ALUop    <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
        end else if (load_id) begin
            ex_valid    <= id_valid;
            ex_Rn       <= id_Rn;
            ex_Rm       <= id_Rm;
            ex_Rd       <= id_Rd;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_ALUSrc   <= id_ALUSrc;
            ex_ALUop    <= id_ALUop;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm      <= id_imm;
            ex_pc       <= id_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (count_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
